// File: rtl/zmod_dac_spi_sequencer_if.sv
// -----------------------------------------------------------------------------
// zmod_dac_spi_sequencer_if
//  AXIS-style runtime register-write channel into the ZMOD DAC SPI sequencer.
//  cfg_tdata  : {instr[7:0], data[7:0]}, transmitted MSB first
//  cfg_tvalid : producer has a write pending
//  cfg_tready : sequencer accepts the write when high together with tvalid
//  master modport = write producer, slave modport = sequencer
// -----------------------------------------------------------------------------
interface zmod_dac_spi_sequencer_if;
   logic [15:0] cfg_tdata;
   logic        cfg_tvalid;
   logic        cfg_tready;

   modport master (output cfg_tdata, output cfg_tvalid, input cfg_tready);
   modport slave  (input cfg_tdata, input cfg_tvalid, output cfg_tready);
endinterface

// File: rtl/zmod_dac_spi_sequencer.sv
// -----------------------------------------------------------------------------
// zmod_dac_spi_sequencer
//  Power-up configuration controller for the AD9717 on the ZMOD DAC.
//  Pulses the DAC reset, waits for the DAC to wake, streams INIT_TABLE over the
//  3-wire SPI (16-bit frames, CPOL=0), then accepts runtime writes over the cfg
//  channel and gates the output relay once the DAC has been configured.
//
//  Ports
//   aclk          clock
//   reset         asynchronous, active-high reset
//   enable_dac    request analog output (relay closed)
//   cfg           runtime write channel (slave side)
//   dac_rst       DAC RESET pin, high = reset
//   spi_cs        active-low chip select
//   spi_sck       SPI clock, idles low
//   spi_sdo       serial data, changes with sck falling, sampled by DAC on rising
//   config_done   init table fully sent; held until reset
//   busy          frame on the wire or inter-frame gap
//   relay_output  ZMOD output relay drive
// -----------------------------------------------------------------------------
module zmod_dac_spi_sequencer #(
   parameter int unsigned             CLK_DIV     = 4,
   parameter int unsigned             RST_CYCLES  = 64,
   parameter int unsigned             WAKE_CYCLES = 1024,
   parameter int unsigned             GAP_CYCLES  = 8,
   parameter int unsigned             N_REGS      = 4,
   parameter logic [N_REGS*16-1:0]    INIT_TABLE  = '0,
   parameter int unsigned             RELAY_DELAY = 256
) (
   input  logic                            aclk,
   input  logic                            reset,
   input  logic                            enable_dac,
   zmod_dac_spi_sequencer_if.slave         cfg,
   output logic                            dac_rst,
   output logic                            spi_cs,
   output logic                            spi_sck,
   output logic                            spi_sdo,
   output logic                            config_done,
   output logic                            busy,
   output logic                            relay_output
);

   typedef enum logic [2:0] {
      ST_RST_HOLD = 3'd0,
      ST_WAKE     = 3'd1,
      ST_LOAD     = 3'd2,
      ST_SHIFT    = 3'd3,
      ST_GAP      = 3'd4,
      ST_READY    = 3'd5
   } state_t;

   localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
   localparam logic [31:0] WAKE_LAST  = 32'(WAKE_CYCLES - 1);
   localparam logic [31:0] DIV_LAST   = 32'(CLK_DIV - 1);
   localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
   // Between init frames the LOAD cycle is itself a cs-high cycle, so the gap
   // count ends one cycle early to keep cs high for exactly GAP_CYCLES.
   localparam logic [31:0] GAP_LOAD_LAST = (GAP_CYCLES >= 2) ? 32'(GAP_CYCLES - 2) : 32'd0;
   localparam logic [31:0] RELAY_LAST = 32'(RELAY_DELAY);
   localparam logic [4:0]  N_ENTRIES  = 5'(N_REGS);

   state_t      state_r;
   logic [31:0] cnt_r;
   logic [31:0] div_cnt_r;
   logic [5:0]  half_cnt_r;
   logic [4:0]  idx_r;
   logic [15:0] sreg_r;
   logic        dac_rst_r;
   logic        spi_cs_r;
   logic        spi_sck_r;
   logic        cfg_tready_r;
   logic        config_done_r;
   logic        busy_r;
   logic [31:0] relay_cnt_r;
   logic        relay_output_r;
   logic [15:0] entry_s;
   logic        more_s;

   // Select one init-table entry; out-of-range indices read as zero.
   function automatic logic [15:0] table_entry(input logic [4:0] i);
      logic [15:0] e;
      e = 16'h0000;
      for (int k = 0; k < int'(N_REGS); k++) begin
         if (i == 5'(k)) begin
            e = INIT_TABLE[k*16 +: 16];
         end else begin
            e = e;
         end
      end
      return e;
   endfunction

   // Next table entry and whether any entries remain to be sent.
   always_comb begin
      entry_s = table_entry(idx_r);
      more_s  = (idx_r < N_ENTRIES);
   end

   // Sequencer FSM: DAC reset, wake wait, init frames, then runtime writes.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_RST_HOLD;
         cnt_r         <= 32'd0;
         div_cnt_r     <= 32'd0;
         half_cnt_r    <= 6'd0;
         idx_r         <= 5'd0;
         sreg_r        <= 16'h0000;
         dac_rst_r     <= 1'b1;
         spi_cs_r      <= 1'b1;
         spi_sck_r     <= 1'b0;
         cfg_tready_r  <= 1'b0;
         config_done_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         case (state_r)
            ST_RST_HOLD: begin
               if (cnt_r >= RST_LAST) begin
                  dac_rst_r <= 1'b0;
                  cnt_r     <= 32'd0;
                  state_r   <= ST_WAKE;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_WAKE: begin
               if (cnt_r >= WAKE_LAST) begin
                  cnt_r   <= 32'd0;
                  state_r <= ST_LOAD;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_LOAD: begin
               // sdo is sreg_r[15], so bit 15 is on the wire as cs falls
               sreg_r     <= entry_s;
               idx_r      <= idx_r + 5'd1;
               spi_cs_r   <= 1'b0;
               spi_sck_r  <= 1'b0;
               div_cnt_r  <= 32'd0;
               half_cnt_r <= 6'd0;
               busy_r     <= 1'b1;
               state_r    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // 32 half-periods give 16 rising edges; cs rises one cycle
               // after the last fall, so cs is low 32*CLK_DIV+1 cycles.
               if (half_cnt_r == 6'd32) begin
                  spi_cs_r <= 1'b1;
                  sreg_r   <= 16'h0000;
                  cnt_r    <= 32'd0;
                  state_r  <= ST_GAP;
               end else if (div_cnt_r >= DIV_LAST) begin
                  div_cnt_r  <= 32'd0;
                  half_cnt_r <= half_cnt_r + 6'd1;
                  spi_sck_r  <= ~spi_sck_r;
                  if (spi_sck_r) begin
                     sreg_r <= {sreg_r[14:0], 1'b0};
                  end else begin
                     sreg_r <= sreg_r;
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + 32'd1;
               end
            end
            ST_GAP: begin
               if (more_s && (cnt_r >= GAP_LOAD_LAST)) begin
                  cnt_r   <= 32'd0;
                  state_r <= ST_LOAD;
               end else if (!more_s && (cnt_r >= GAP_LAST)) begin
                  cnt_r         <= 32'd0;
                  busy_r        <= 1'b0;
                  config_done_r <= 1'b1;
                  cfg_tready_r  <= 1'b1;
                  state_r       <= ST_READY;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_READY: begin
               if (cfg.cfg_tvalid && cfg_tready_r) begin
                  sreg_r       <= cfg.cfg_tdata;
                  cfg_tready_r <= 1'b0;
                  spi_cs_r     <= 1'b0;
                  spi_sck_r    <= 1'b0;
                  div_cnt_r    <= 32'd0;
                  half_cnt_r   <= 6'd0;
                  busy_r       <= 1'b1;
                  state_r      <= ST_SHIFT;
               end else begin
                  cfg_tready_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= ST_RST_HOLD;
               cnt_r        <= 32'd0;
               dac_rst_r    <= 1'b1;
               spi_cs_r     <= 1'b1;
               spi_sck_r    <= 1'b0;
               sreg_r       <= 16'h0000;
               cfg_tready_r <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   // Relay delay counter from config_done, and the registered relay drive.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         relay_cnt_r    <= 32'd0;
         relay_output_r <= 1'b0;
      end else begin
         if (config_done_r && (relay_cnt_r < RELAY_LAST)) begin
            relay_cnt_r <= relay_cnt_r + 32'd1;
         end else begin
            relay_cnt_r <= relay_cnt_r;
         end
         relay_output_r <= enable_dac && config_done_r && (relay_cnt_r >= RELAY_LAST);
      end
   end

   assign cfg.cfg_tready = cfg_tready_r;
   assign dac_rst        = dac_rst_r;
   assign spi_cs         = spi_cs_r;
   assign spi_sck        = spi_sck_r;
   assign spi_sdo        = sreg_r[15];
   assign config_done    = config_done_r;
   assign busy           = busy_r;
   assign relay_output   = relay_output_r;

endmodule

// File: tb/tb_zmod_dac_spi_sequencer.sv
module tb_zmod_dac_spi_sequencer;
   localparam int CD = 2;
   localparam int RC = 4;
   localparam int WC = 10;
   localparam int GC = 4;
   localparam int NR = 2;
   localparam int RD = 40;

   logic aclk = 1'b0;
   logic reset;
   logic enable_dac;
   logic dac_rst, spi_cs, spi_sck, spi_sdo, config_done, busy, relay_output;

   zmod_dac_spi_sequencer_if cfg_if();

   zmod_dac_spi_sequencer #(
      .CLK_DIV(CD), .RST_CYCLES(RC), .WAKE_CYCLES(WC), .GAP_CYCLES(GC),
      .N_REGS(NR), .INIT_TABLE({16'h0380, 16'h0212}), .RELAY_DELAY(RD)
   ) dut (
      .aclk(aclk), .reset(reset), .enable_dac(enable_dac), .cfg(cfg_if),
      .dac_rst(dac_rst), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_sdo(spi_sdo),
      .config_done(config_done), .busy(busy), .relay_output(relay_output)
   );

   always #5 aclk = ~aclk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cyc = -1;
   int relay_cyc = -1;

   // timestamps of first config_done / relay_output high
   always @(negedge aclk) begin
      cyc = cyc + 1;
      if (config_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (relay_output === 1'b1 && relay_cyc < 0) relay_cyc = cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cs_low(input int budget, output int waited, output int rdy, output bit ok);
      waited = 0;
      rdy = 0;
      while (spi_cs !== 1'b0 && waited < budget) begin
         if (cfg_if.cfg_tready === 1'b1) rdy++;
         @(negedge aclk);
         waited++;
      end
      ok = (spi_cs === 1'b0);
   endtask

   task automatic capture_frame(output logic [15:0] w, output int nbits, output int low_cyc);
      logic prev;
      w = 16'h0000;
      nbits = 0;
      low_cyc = 0;
      prev = spi_sck;
      while (spi_cs === 1'b0 && low_cyc < 500) begin
         if (spi_sck === 1'b1 && prev === 1'b0) begin
            w = {w[14:0], spi_sdo};
            nbits++;
         end
         prev = spi_sck;
         @(negedge aclk);
         low_cyc++;
      end
   endtask

   initial begin
      logic [15:0] word;
      int nb, lc, n, w, rdy, k;
      bit ok;
      logic prev;

      reset = 1'b1;
      enable_dac = 1'b1;
      cfg_if.cfg_tvalid = 1'b1;
      cfg_if.cfg_tdata = 16'h0A55;
      repeat (3) @(negedge aclk);

      chk("rst_dac_rst", 32'(dac_rst), 32'd1);
      chk("rst_cs", 32'(spi_cs), 32'd1);
      chk("rst_sck", 32'(spi_sck), 32'd0);
      chk("rst_sdo", 32'(spi_sdo), 32'd0);
      chk("rst_tready", 32'(cfg_if.cfg_tready), 32'd0);
      chk("rst_done", 32'(config_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_relay", 32'(relay_output), 32'd0);

      // reset release timing
      reset = 1'b0;
      n = 0;
      while (dac_rst === 1'b1 && n < 1000) begin
         @(negedge aclk);
         n++;
      end
      chk("dac_rst_hold", 32'(n), 32'(RC));
      wait_cs_low(2000, w, rdy, ok);
      chk("first_cs_seen", 32'(ok), 32'd1);
      chk("first_cs_fall", 32'(n + w), 32'(RC + WC + 1));
      chk("tready_held_off_wake", 32'(rdy), 32'd0);
      chk("busy_frame0", 32'(busy), 32'd1);

      // init frames
      capture_frame(word, nb, lc);
      chk("frame0_data", 32'(word), 32'h0212);
      chk("frame0_bits", 32'(nb), 32'd16);
      chk("frame0_len", 32'(lc), 32'(32 * CD + 1));
      chk("gap0_sdo", 32'(spi_sdo), 32'd0);
      chk("gap0_busy", 32'(busy), 32'd1);
      wait_cs_low(200, w, rdy, ok);
      chk("frame1_seen", 32'(ok), 32'd1);
      chk("gap0_len", 32'(w), 32'(GC));
      chk("tready_held_off_init", 32'(rdy), 32'd0);
      capture_frame(word, nb, lc);
      chk("frame1_data", 32'(word), 32'h0380);
      chk("frame1_bits", 32'(nb), 32'd16);
      chk("done_before_gap", 32'(config_done), 32'd0);

      // pending write from reset gets exactly one handshake
      wait_cs_low(200, w, rdy, ok);
      chk("cfg_frame_seen", 32'(ok), 32'd1);
      chk("cfg_hs_gap", 32'(w), 32'(GC + 1));
      chk("cfg_one_handshake", 32'(rdy), 32'd1);
      chk("done_high", 32'(config_done), 32'd1);
      chk("tready_in_shift", 32'(cfg_if.cfg_tready), 32'd0);
      cfg_if.cfg_tvalid = 1'b0;
      capture_frame(word, nb, lc);
      chk("cfg_data", 32'(word), 32'h0A55);
      chk("cfg_bits", 32'(nb), 32'd16);
      chk("cfg_len", 32'(lc), 32'(32 * CD + 1));
      repeat (GC - 1) @(negedge aclk);
      chk("tready_low_in_gap", 32'(cfg_if.cfg_tready), 32'd0);
      chk("busy_in_gap", 32'(busy), 32'd1);
      @(negedge aclk);
      chk("tready_after_gap", 32'(cfg_if.cfg_tready), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);

      // relay delay
      chk("relay_delay", 32'(relay_cyc - done_cyc), 32'(RD + 1));
      chk("relay_closed", 32'(relay_output), 32'd1);

      // back-to-back writes, relay opened mid-frame
      cfg_if.cfg_tdata = 16'h0101;
      cfg_if.cfg_tvalid = 1'b1;
      wait_cs_low(200, w, rdy, ok);
      chk("b2b0_seen", 32'(ok), 32'd1);
      cfg_if.cfg_tdata = 16'h0202;
      enable_dac = 1'b0;
      @(negedge aclk);
      chk("relay_open", 32'(relay_output), 32'd0);
      capture_frame(word, nb, lc);
      chk("b2b0_data", 32'(word), 32'h0101);
      chk("b2b0_bits", 32'(nb), 32'd16);
      wait_cs_low(200, w, rdy, ok);
      chk("b2b1_seen", 32'(ok), 32'd1);
      chk("b2b_gap_min", 32'(w >= GC), 32'd1);
      cfg_if.cfg_tvalid = 1'b0;
      capture_frame(word, nb, lc);
      chk("b2b1_data", 32'(word), 32'h0202);
      chk("b2b1_bits", 32'(nb), 32'd16);

      // reset at bit 7 of a frame
      repeat (GC + 1) @(negedge aclk);
      cfg_if.cfg_tdata = 16'hC3A5;
      cfg_if.cfg_tvalid = 1'b1;
      wait_cs_low(200, w, rdy, ok);
      chk("abort_frame_seen", 32'(ok), 32'd1);
      cfg_if.cfg_tvalid = 1'b0;
      nb = 0;
      k = 0;
      prev = spi_sck;
      while (nb < 9 && k < 500) begin
         @(negedge aclk);
         k++;
         if (spi_sck === 1'b1 && prev === 1'b0) nb++;
         prev = spi_sck;
      end
      reset = 1'b1;
      #1;
      chk("abort_cs", 32'(spi_cs), 32'd1);
      chk("abort_sck", 32'(spi_sck), 32'd0);
      chk("abort_dac_rst", 32'(dac_rst), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(config_done), 32'd0);
      @(negedge aclk);
      @(negedge aclk);
      reset = 1'b0;
      n = 0;
      while (dac_rst === 1'b1 && n < 1000) begin
         @(negedge aclk);
         n++;
      end
      chk("reinit_dac_rst_hold", 32'(n), 32'(RC));
      wait_cs_low(2000, w, rdy, ok);
      chk("reinit_cs_fall", 32'(n + w), 32'(RC + WC + 1));
      capture_frame(word, nb, lc);
      chk("reinit_frame0", 32'(word), 32'h0212);
      chk("reinit_frame0_bits", 32'(nb), 32'd16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
